nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
Multi-word adder that adds two WIDTH-bit operands serially, one 4-bit slice per clock. It reuses a single 4-bit ripple-carry datapath (four 1-bit full adders, gate-level) and keeps the carry in a flip-flop between slices. It sits directly upstream of, and wraps, the 4-bit ripple-carry adder: it sequences operand nibbles into that adder and consumes the sum and carry it produces. A start/busy/done handshake exposes it to the rest of the design.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived number of slices; not overridden by the user.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while slices are being added (RUN).
- done  output  1  one-cycle pulse; sum, cout and ovf are valid.
- sum  output  WIDTH  result, assembled one nibble per cycle.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock (clk). Synchronous, active-high reset (rst).
- Reset effects (rst=1 at an edge):
  - state goes to IDLE; slice index 0; carry register 0; operand registers 0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - rst has priority over start and over every state.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge t0: capture a, b and cin into the operand and carry registers; index<=0; sum<=0; cout<=0; ovf<=0; go to RUN.
  - Otherwise hold state; sum, cout and ovf keep the last result.
- RUN (busy=1):
  - Each edge computes a_reg[4i+3:4i] + b_reg[4i+3:4i] + carry through the 4-bit ripple adder.
  - It writes sum[4i+3:4i], loads carry<=adder carry-out, and increments the index.
  - At index NIBBLES-1 it also sets cout=adder carry-out and ovf=(carry into bit 3 of the slice) XOR (carry-out), then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then go to IDLE.
  - start is ignored in DONE.
  - A start is accepted in the first IDLE cycle after DONE, which gives a restart every NIBBLES+2 cycles.
- Latency for start accepted at edge t0:
  - busy is high from after t0 until edge t0+NIBBLES.
  - done is high between edges t0+NIBBLES and t0+NIBBLES+1.
- start while busy or done is ignored; the captured operands are unaffected by later changes on a, b or cin.
- sum is valid only when done=1 or afterwards in IDLE; partial slices are visible during RUN and must not be consumed.
- Result is modulo 2^WIDTH. A carry ripples across slice boundaries only through the carry register.
- Reset mid-operation aborts the operation: no done pulse, all outputs return to 0, next start is accepted normally.
- start held high continuously starts a new addition every NIBBLES+2 cycles.

Test Plan (WIDTH=16):
- Reset: rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0x0000, cout=0, ovf=0 throughout.
- Basic add: a=0x1234, b=0x4321, cin=0, start at t0 -> busy for 4 cycles; done at t0+4 with sum=0x5555, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x0000, b=0xFFFF, cin=1 -> same result.
- Signed overflow:
  - 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000, cin=1 -> sum=0x0001, cout=1, ovf=1.
- Handshake: change a/b and pulse start during RUN -> ignored, result matches the operands captured at t0. start held high -> second done exactly 6 cycles after the first.
- Reset mid-op: start 0x00FF+0x0001, assert rst at edge t0+2 -> no done, sum=0. Then a fresh start of 0x0001+0x0001 -> done 4 cycles later with sum=0x0002.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands one 4-bit slice per clock through a single
//   gate-level 4-bit ripple-carry adder. The carry between slices is kept in
//   a flip-flop, so a carry crosses slice boundaries only through that register.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous reset, active-high, priority over everything
//   start  request a new addition (accepted only in IDLE)
//   a, b   WIDTH-bit operands, captured on the accepted start
//   cin    carry-in, captured on the accepted start
//   busy   high while slices are being added
//   done   one-cycle pulse, sum/cout/ovf valid
//   sum    result, assembled one nibble per cycle (partial during busy)
//   cout   carry out of bit WIDTH-1
//   ovf    two's-complement overflow of the full-width add

// 1-bit full adder built from gate primitives.
module nsa_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  logic g;
  logic t;

  xor u_p  (p, x, y);
  xor u_s  (s, p, ci);
  and u_g  (g, x, y);
  and u_t  (t, p, ci);
  or  u_co (co, g, t);
endmodule

// 4-bit ripple-carry adder. c3 is the carry into bit 3, needed for overflow.
module nsa_ripple4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    nsa_full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[4];
  assign c3 = c[3];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry;

  logic               accept;
  logic               step;
  logic               last;

  logic [IDX_W+1:0]   base;
  logic [3:0]         slice_sum;
  logic               slice_co;
  logic               slice_c3;

  // Slice base bit = 4 * idx.
  assign base = {idx, 2'b00};
  assign last = (idx == IDX_W'(NIBBLES - 1));

  nsa_ripple4 u_adder (
    .x  (a_reg[base +: 4]),
    .y  (b_reg[base +: 4]),
    .ci (carry),
    .s  (slice_sum),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and control decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers.
  // NOTE: these are a handful of control/data flops, not a memory array, so
  // they are all cleared by reset; an abort must leave the outputs at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      a_reg <= a;
      b_reg <= b;
      carry <= cin;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (step) begin
      sum[base +: 4] <= slice_sum;
      carry          <= slice_co;
      idx            <= idx + 1'b1;
      if (last) begin
        cout <= slice_co;
        ovf  <= slice_c3 ^ slice_co;
      end
    end
  end

endmodule
